vector_mac_unit: RTL and testbench
==================================

Name: vector_mac_unit

Overview:
Parametrised multiply-accumulate vector unit. Computes a signed dot product of VEC_LEN (xin, w) element pairs through a registered multiply stage and an accumulate stage. Uses valid/ready handshakes on input and result. Forwards xin one cycle later so units can be chained systolically in the NN datapath.

Parameters:
DATA_W, 8, signed width of xin, w and xout
ACC_W, 32, signed width of accumulator and result; must be >= 2*DATA_W
VEC_LEN, 16, elements per dot product; must be >= 1
CNT_W, $clog2(VEC_LEN+1), element counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
clear  in  1  synchronous abort of the current vector
in_valid  in  1  xin/w pair valid
in_ready  out  1  unit accepts a pair this cycle
xin  in  DATA_W  signed activation
w  in  DATA_W  signed weight
xout  out  DATA_W  registered copy of the last accepted xin
xout_valid  out  1  pulses one cycle after each accept
out_valid  out  1  result held in accum
out_ready  in  1  downstream consumes result
accum  out  ACC_W  signed dot-product result
sat_flag  out  1  sticky overflow indicator for the current result
busy  out  1  vector partially accepted or products in flight

Behaviour:
- Reset (rst==0 at a clk edge): all registers clear. accum=0, out_valid=0, xout=0, xout_valid=0, sat_flag=0, busy=0, and the counter and pipeline valid bits are 0. in_ready is 0 while rst==0.
- Stall condition: stall = out_valid & ~out_ready.
- advance = ~stall. in_ready = advance & ~clear & rst (combinational).
- Every pipeline register is enabled only on advance, so a stall freezes in-flight products.
- Accept: in_valid & in_ready. On accept:
  - Stage-1 registers prod = xin*w (full signed 2*DATA_W) with a last tag when count==VEC_LEN-1.
  - xout <= xin.
  - count increments; count wraps to 0 after the last element.
- xout_valid = 1 in the cycle after an accept, otherwise 0. xout holds its value when there is no accept.
- Stage 2 (on advance with a valid stage-1 product):
  - The product is sign-extended to ACC_W.
  - If it is the first element of a vector, the accumulator loads the product; otherwise it adds the product to the accumulator.
  - If the product carries the last tag, the sum goes to accum, out_valid is set, and the internal accumulator becomes free for the next vector.
- Latency: the last element accepted at edge T gives out_valid=1 and a valid accum after edge T+2, with no stall.
- Back-to-back vectors need no bubble. The first element of vector N+1 may be accepted the cycle after the last element of vector N.
- Result handshake:
  - out_valid & out_ready at an edge consumes the result.
  - If a new last result completes at the same edge, out_valid stays 1 with the new accum. Otherwise out_valid clears.
  - accum holds its last value after it is consumed.
- Arithmetic wraps in two's complement by default. sat_flag=0 by default.
- busy = (count!=0) | any stage-1/stage-2 valid bit set.
- clear==1 at an edge:
  - The counter, pipeline valid bits, the internal accumulator and sat_flag go to 0.
  - No accept happens in that cycle.
  - A pending out_valid result is kept.
- rst takes priority over clear. Reset in mid-vector discards all partial state.

Optional Feature:
MAC_SAT_EN
- Defined: each stage-2 add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp during a vector sets sat_flag.
  - sat_flag is presented with accum and cleared when the next vector's first product loads.
- Not defined: wrapping arithmetic and sat_flag tied to 0.
- Latency is identical in both builds.

Test Plan:
- VEC_LEN=4, four pairs (1,1) on consecutive cycles, out_ready=1 -> out_valid one cycle, 2 cycles after the last accept, accum=4. xout_valid pulses 4 times with xout=1.
- VEC_LEN=4, xin=-128, w=-128 four times -> accum=65536. Then xin=3, w=-5 four times back-to-back -> accum=-60 with no input bubble.
- out_ready=0 when a result completes, in_valid held high -> in_ready=0, accum and out_valid held. Raise out_ready -> exactly one result is consumed, then accepts resume and the next result is correct.
- VEC_LEN=4, accept 2 pairs (2,2), pulse clear, then 4 pairs (1,1) -> accum=4, sat_flag=0. rst low mid-vector -> all outputs 0, and the next full vector is correct.
- ACC_W=16, DATA_W=8, VEC_LEN=3, xin=w=127 three times -> with MAC_SAT_EN: accum=32767, sat_flag=1. Without it: accum=-17149, sat_flag=0.

Source files
------------

// File: rtl/vector_mac_unit_if.sv
// Handshake bundle for vector_mac_unit: operand input side,
// systolic xin forward and result output side.
interface vector_mac_unit_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] xin;
  logic signed [DATA_W-1:0] w;
  logic signed [DATA_W-1:0] xout;
  logic                     xout_valid;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  accum;
  logic                     sat_flag;

  modport master (
    output in_valid, xin, w, out_ready,
    input  in_ready, xout, xout_valid,
    input  out_valid, accum, sat_flag
  );

  modport slave (
    input  in_valid, xin, w, out_ready,
    output in_ready, xout, xout_valid,
    output out_valid, accum, sat_flag
  );
endinterface

// File: rtl/vector_mac_unit.sv
// Signed dot-product MAC: multiply stage, accumulate stage, result reg.
// Define MAC_SAT_EN for saturating accumulation with a sticky sat_flag.
module vector_mac_unit #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int VEC_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  output logic        busy,
  vector_mac_unit_if.slave bus
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int PW    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  logic [CNT_W-1:0]         count;
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;
  logic signed [PW-1:0]     prod;
  logic                     s2_valid;
  logic                     s2_last;
  logic signed [ACC_W-1:0]  acc;
  logic                     sat_acc;
  logic signed [ACC_W-1:0]  accum;
  logic                     sat;
  logic                     out_valid;
  logic signed [DATA_W-1:0] xout;
  logic                     xout_valid;

  logic                     advance;
  logic                     accept;
  logic signed [PW-1:0]     prod_d;
  logic signed [ACC_W-1:0]  addend;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;
  logic                     sat_d;

  assign advance      = ~(out_valid & ~bus.out_ready);
  assign bus.in_ready = advance & ~clear & rst;
  assign accept       = bus.in_valid & bus.in_ready;

  assign prod_d = PW'(bus.xin) * PW'(bus.w);
  assign addend = ACC_W'(prod);
  assign base   = s1_first ? '0 : acc;

`ifdef MAC_SAT_EN
  logic [ACC_W:0] wide;
  logic           ovf;

  assign wide = {base[ACC_W-1], base} + {addend[ACC_W-1], addend};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    sum = wide[ACC_W-1:0];
    if (ovf)
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                        : {1'b0, {(ACC_W-1){1'b1}}};
  end

  assign sat_d = (~s1_first & sat_acc) | ovf;
`else
  assign sum   = base + addend;
  assign sat_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= '0;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      prod       <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      acc        <= '0;
      sat_acc    <= 1'b0;
      accum      <= '0;
      sat        <= 1'b0;
      out_valid  <= 1'b0;
      xout       <= '0;
      xout_valid <= 1'b0;
    end else begin
      xout_valid <= accept;
      if (accept)
        xout <= bus.xin;
      if (out_valid && bus.out_ready)
        out_valid <= 1'b0;
      if (clear) begin
        count    <= '0;
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        acc      <= '0;
        sat_acc  <= 1'b0;
        sat      <= 1'b0;
      end else if (advance) begin
        s1_valid <= accept;
        if (accept) begin
          prod     <= prod_d;
          s1_first <= (count == '0);
          s1_last  <= (count == LAST);
          count    <= (count == LAST) ? '0 : count + 1'b1;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          acc     <= sum;
          sat_acc <= sat_d;
          s2_last <= s1_last;
          if (s1_first)
            sat <= 1'b0;
        end
        // a finishing vector's flag wins over the next vector's first load
        if (s2_valid && s2_last) begin
          accum     <= acc;
          out_valid <= 1'b1;
          sat       <= sat_acc;
        end
      end
    end
  end

  assign bus.xout       = xout;
  assign bus.xout_valid = xout_valid;
  assign bus.out_valid  = out_valid;
  assign bus.accum      = accum;
  assign bus.sat_flag   = sat;
  assign busy = (count != '0) | s1_valid | s2_valid;
endmodule

// File: tb/tb_vector_mac_unit.sv
// Bench for vector_mac_unit: VEC_LEN=4/ACC_W=32 unit plus a
// VEC_LEN=3/ACC_W=16 unit for the overflow case.
module tb_vector_mac_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic busy4, busy3;

  always #5 clk = ~clk;

  vector_mac_unit_if #(.DATA_W(8), .ACC_W(32)) b4 ();
  vector_mac_unit_if #(.DATA_W(8), .ACC_W(16)) b3 ();

  vector_mac_unit #(.DATA_W(8), .ACC_W(32), .VEC_LEN(4)) u4 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy4), .bus(b4.slave));
  vector_mac_unit #(.DATA_W(8), .ACC_W(16), .VEC_LEN(3)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy3), .bus(b3.slave));

  int n_checks = 0;
  int n_fail = 0;

  int mx[$];
  int mw[$];
  int msum;
  logic signed [31:0] exp_q[$];
  logic signed [31:0] got_q[$];
  logic got_sat[$];

  // reference model: collect accepted pairs, dot product per 4 elements
  always @(negedge clk) begin
    if (!rst || clear) begin
      mx.delete();
      mw.delete();
    end else if (b4.in_valid && b4.in_ready) begin
      mx.push_back(int'(b4.xin));
      mw.push_back(int'(b4.w));
      if (mx.size() == 4) begin
        msum = 0;
        foreach (mx[i]) msum += mx[i] * mw[i];
        exp_q.push_back(32'(msum));
        mx.delete();
        mw.delete();
      end
    end
    if (rst && b4.out_valid && b4.out_ready) begin
      got_q.push_back(b4.accum);
      got_sat.push_back(b4.sat_flag);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    got_sat.delete();
  endtask

  task automatic send_pair(input int x, input int wv, input bit rnd);
    int budget;
    bit ok;
    budget = 0;
    ok = 1'b0;
    b4.xin = 8'(x);
    b4.w = 8'(wv);
    b4.in_valid = 1'b1;
    do begin
      if (rnd) b4.out_ready = 1'($urandom_range(0, 1));
      #1;
      ok = b4.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!ok && budget < 200);
    b4.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_pair: in_ready=0 for %0d cycles, required 1", budget);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    while ((busy4 || b4.out_valid) && k < 50) begin
      step();
      k++;
    end
    n_checks++;
    if (busy4 !== 1'b0 || b4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: busy=%0b out_valid=%0b, required 0 0",
               busy4, b4.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b4.in_valid = 1'b1;
    b4.xin = 8'sd5;
    b4.w = 8'sd5;
    step();
    step();
    n_checks++;
    if (b4.accum !== 32'sd0) begin
      n_fail++; $display("FAIL rst_accum: got %0d, required 0", b4.accum);
    end
    n_checks++;
    if (b4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_out_valid: got %b, required 0", b4.out_valid);
    end
    n_checks++;
    if (b4.xout !== 8'sd0 || b4.xout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_xout: got %0d/%b, required 0/0", b4.xout, b4.xout_valid);
    end
    n_checks++;
    if (b4.sat_flag !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: sat=%b busy=%b, required 0 0", b4.sat_flag, busy4);
    end
    n_checks++;
    if (b4.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_ready: got %b, required 0", b4.in_ready);
    end
    n_checks++;
    if (b3.accum !== 16'sd0 || b3.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_u3: accum=%0d ov=%b, required 0 0", b3.accum, b3.out_valid);
    end
    b4.in_valid = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    clear_q();
    b4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.in_valid = 1'b1;
      b4.xin = 8'sd1;
      b4.w = 8'sd1;
      step();
      n_checks++;
      if (b4.xout_valid !== 1'b1 || b4.xout !== 8'sd1) begin
        n_fail++;
        $display("FAIL single_xout[%0d]: got %b/%0d, required 1/1",
                 i, b4.xout_valid, b4.xout);
      end
    end
    b4.in_valid = 1'b0;
    n_checks++;
    if (b4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_lat0: out_valid=%b, required 0", b4.out_valid);
    end
    step();
    n_checks++;
    if (b4.out_valid !== 1'b0 || b4.xout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat1: out_valid=%b xout_valid=%b, required 0 0",
               b4.out_valid, b4.xout_valid);
    end
    step();
    n_checks++;
    if (b4.out_valid !== 1'b1 || b4.accum !== 32'sd4) begin
      n_fail++;
      $display("FAIL single_lat2: out_valid=%b accum=%0d, required 1 4",
               b4.out_valid, b4.accum);
    end
    step();
    n_checks++;
    if (b4.out_valid !== 1'b0 || b4.accum !== 32'sd4) begin
      n_fail++;
      $display("FAIL single_hold: out_valid=%b accum=%0d, required 0 4",
               b4.out_valid, b4.accum);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int i = 0; i < 8; i++) begin
      b4.in_valid = 1'b1;
      b4.xin = (i < 4) ? -8'sd128 : 8'sd3;
      b4.w = (i < 4) ? -8'sd128 : -8'sd5;
      #1;
      n_checks++;
      if (b4.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, b4.in_ready);
      end
      @(posedge clk);
      #1;
    end
    drain();
    n_checks++;
    if (got_q.size() !== 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d results, required 2", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== 32'sd65536 || got_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL b2b_v0: got %0d, required 65536", got_q[0]);
      end
      n_checks++;
      if (got_q[1] !== -32'sd60 || got_q[1] !== exp_q[1]) begin
        n_fail++; $display("FAIL b2b_v1: got %0d, required -60", got_q[1]);
      end
    end
  endtask

  task automatic test_stall();
    logic signed [31:0] held;
    clear_q();
    b4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_pair($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b0);
    for (int i = 0; i < 2; i++) begin
      b4.in_valid = 1'b1;
      b4.xin = 8'($urandom);
      b4.w = 8'($urandom);
      step();
    end
    b4.xin = 8'($urandom);
    b4.w = 8'($urandom);
    held = b4.accum;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (b4.in_ready !== 1'b0 || b4.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b, required 0 1",
                 i, b4.in_ready, b4.out_valid);
      end
      n_checks++;
      if (b4.accum !== exp_q[0] || b4.accum !== held) begin
        n_fail++;
        $display("FAIL stall_accum[%0d]: got %0d, required %0d", i, b4.accum, exp_q[0]);
      end
    end
    b4.out_ready = 1'b1;
    step();
    b4.in_valid = 1'b0;
    n_checks++;
    if (got_q.size() !== 1 || b4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: results=%0d out_valid=%b, required 1 0",
               got_q.size(), b4.out_valid);
    end
    send_pair($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b0);
    drain();
    n_checks++;
    if (got_q.size() !== 2 || exp_q.size() !== 2) begin
      n_fail++;
      $display("FAIL stall_count: got %0d results, required 2", got_q.size());
    end else begin
      n_checks++;
      if (got_q[1] !== exp_q[1]) begin
        n_fail++; $display("FAIL stall_next: got %0d, required %0d", got_q[1], exp_q[1]);
      end
    end
  endtask

  task automatic test_clear();
    clear_q();
    send_pair(2, 2, 1'b0);
    send_pair(2, 2, 1'b0);
    clear = 1'b1;
    b4.in_valid = 1'b1;
    b4.xin = 8'sd9;
    b4.w = 8'sd9;
    #1;
    n_checks++;
    if (b4.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_ready: got %b, required 0", b4.in_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    b4.in_valid = 1'b0;
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL clear_busy: got %b, required 0", busy4);
    end
    for (int i = 0; i < 4; i++) send_pair(1, 1, 1'b0);
    drain();
    n_checks++;
    if (got_q.size() !== 1) begin
      n_fail++; $display("FAIL clear_count: got %0d results, required 1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== 32'sd4 || got_sat[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_result: got %0d sat=%b, required 4 0", got_q[0], got_sat[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    send_pair(7, 7, 1'b0);
    send_pair(-3, 11, 1'b0);
    rst = 1'b0;
    step();
    n_checks++;
    if (b4.accum !== 32'sd0 || b4.out_valid !== 1'b0 || busy4 !== 1'b0 ||
        b4.xout !== 8'sd0 || b4.xout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: accum=%0d ov=%b busy=%b xout=%0d xv=%b, required all 0",
               b4.accum, b4.out_valid, busy4, b4.xout, b4.xout_valid);
    end
    rst = 1'b1;
    clear_q();
    for (int i = 0; i < 4; i++)
      send_pair($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b0);
    drain();
    n_checks++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      n_fail++; $display("FAIL midrst_count: got %0d results, required 1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== exp_q[0]) begin
        n_fail++; $display("FAIL midrst_result: got %0d, required %0d", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int v = 0; v < 6; v++) begin
      for (int e = 0; e < 4; e++) begin
        if ($urandom_range(0, 3) == 0) begin
          b4.out_ready = 1'($urandom_range(0, 1));
          step();
        end
        send_pair($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b1);
      end
    end
    drain();
    n_checks++;
    if (got_q.size() !== 6 || exp_q.size() !== 6) begin
      n_fail++; $display("FAIL rand_count: got %0d results, required 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_v%0d: got %0d, required %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_sat();
    longint s;
    bit f;
    logic signed [15:0] expv;
    int k;
    s = 0;
    f = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s += 127 * 127;
`ifdef MAC_SAT_EN
      if (s > 32767) begin
        s = 32767;
        f = 1'b1;
      end
`endif
    end
    expv = 16'(s);
    b3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b3.in_valid = 1'b1;
      b3.xin = 8'sd127;
      b3.w = 8'sd127;
      #1;
      n_checks++;
      if (b3.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL sat_ready[%0d]: got %b, required 1", i, b3.in_ready);
      end
      @(posedge clk);
      #1;
    end
    b3.in_valid = 1'b0;
    k = 0;
    while (!b3.out_valid && k < 10) begin
      step();
      k++;
    end
    n_checks++;
    if (b3.out_valid !== 1'b1 || b3.accum !== expv || b3.sat_flag !== f) begin
      n_fail++;
      $display("FAIL sat_result: ov=%b accum=%0d sat=%b, required 1 %0d %b",
               b3.out_valid, b3.accum, b3.sat_flag, expv, f);
    end
    step();
    step();
  endtask

  initial begin
    b4.in_valid = 1'b0;
    b4.xin = '0;
    b4.w = '0;
    b4.out_ready = 1'b1;
    b3.in_valid = 1'b0;
    b3.xin = '0;
    b3.w = '0;
    b3.out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_clear();
    test_reset_mid();
    test_random();
    test_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
